// File: rtl/issue_queue_free_list_pkg.sv
// Types and constants shared by the issue-queue free list and its compactor.
// Ports: none (package). Optional feature macro: ISSUE_QUEUE_FREE_LIST_CHECK_EN.
package issue_queue_free_list_pkg;

  localparam int unsigned ISSUE_QUEUE_ENTRY_NUM = 16;
  localparam int unsigned RENAME_WIDTH          = 2;
  localparam int unsigned ISSUE_WIDTH           = 2;
  localparam int unsigned ISSUE_QUEUE_RETURN_INDEX_WIDTH = 2;

  localparam int unsigned ENTRY_NUM   = ISSUE_QUEUE_ENTRY_NUM;
  localparam int unsigned ALLOC_WIDTH = RENAME_WIDTH;
  localparam int unsigned FREE_WIDTH  = ISSUE_WIDTH + ISSUE_QUEUE_RETURN_INDEX_WIDTH;

  localparam int unsigned IDX_W        = $clog2(ENTRY_NUM);
  localparam int unsigned CNT_W        = $clog2(ENTRY_NUM + 1);
  localparam int unsigned REL_RANK_W   = $clog2(FREE_WIDTH + 1);
  localparam int unsigned ALLOC_RANK_W = $clog2(ALLOC_WIDTH + 1);

  localparam int unsigned ISSUE_QUEUE_FREE_LIST_INIT_CYCLE =
    (ENTRY_NUM + FREE_WIDTH - 1) / FREE_WIDTH;
  localparam int unsigned INIT_CNT_W = $clog2(ISSUE_QUEUE_FREE_LIST_INIT_CYCLE + 1);

  typedef logic [IDX_W-1:0]      IssueQueueIndexPath;
  typedef logic [CNT_W-1:0]      IssueQueueCountPath;
  typedef logic [INIT_CNT_W-1:0] IssueQueueFreeListInitCountPath;

  typedef enum logic {IQ_FL_INIT, IQ_FL_READY} IssueQueueFreeListState;

  // One free-list memory write lane.
  typedef struct packed {
    logic               we;
    IssueQueueIndexPath addr;
    IssueQueueIndexPath data;
  } fl_write_t;

  // Circular pointer add with explicit wrap; inc never exceeds ENTRY_NUM.
  function automatic IssueQueueIndexPath wrap_add(IssueQueueIndexPath p, int unsigned inc);
    int unsigned s;
    s = 32'(p) + inc;
    if (s >= ENTRY_NUM) s = s - ENTRY_NUM;
    return IssueQueueIndexPath'(s);
  endfunction

endpackage

// File: rtl/issue_queue_free_list_compactor.sv
// Prefix popcount: rank_o[i] = number of set valid_i bits below lane i,
// total_o = number of set bits overall.
// Ports: valid_i (lane strobes), rank_o (per-lane rank), total_o (popcount).
module issue_queue_free_list_compactor #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned RANK_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]             valid_i,
  output logic [LANES-1:0][RANK_W-1:0] rank_o,
  output logic [RANK_W-1:0]            total_o
);

  // Running exclusive prefix sum over lanes.
  always_comb begin
    logic [RANK_W-1:0] acc;
    acc = '0;
    rank_o = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      rank_o[i] = acc;
      acc = acc + RANK_W'(valid_i[i]);
    end
    total_o = acc;
  end

endmodule

// File: rtl/issue_queue_free_list.sv
// Circular free list of issue-queue entry indices. After reset an INIT
// sequence loads every index once; afterwards dispatch pops ALLOC_WIDTH-wide
// groups from the head and release lanes push compacted indices at the tail.
// Ports: clk, rst_n (async active-low); allocReq/allocPtr/allocatable (dispatch);
// releaseValid/releasePtr (release); freeCount, initDone (status);
// doubleFreeError only when ISSUE_QUEUE_FREE_LIST_CHECK_EN is defined.
module issue_queue_free_list
  import issue_queue_free_list_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ALLOC_WIDTH-1:0]            allocReq,
  output logic [ALLOC_WIDTH-1:0][IDX_W-1:0] allocPtr,
  output logic                              allocatable,
  input  logic [FREE_WIDTH-1:0]             releaseValid,
  input  logic [FREE_WIDTH-1:0][IDX_W-1:0]  releasePtr,
  output logic [CNT_W-1:0]                  freeCount,
  output logic                              initDone
`ifdef ISSUE_QUEUE_FREE_LIST_CHECK_EN
  ,
  output logic                              doubleFreeError
`endif
);

  IssueQueueFreeListState         state_q, state_d;
  IssueQueueIndexPath             head_q, head_d;
  IssueQueueIndexPath             tail_q, tail_d;
  IssueQueueCountPath             count_q, count_d;
  IssueQueueFreeListInitCountPath init_cnt_q, init_cnt_d;
  logic                           init_done_q, init_done_d;

  IssueQueueIndexPath mem_q [ENTRY_NUM];
  fl_write_t          wr_c  [FREE_WIDTH];

  logic [FREE_WIDTH-1:0][REL_RANK_W-1:0]    rel_rank;
  logic [REL_RANK_W-1:0]                    rel_total;
  logic [ALLOC_WIDTH-1:0][ALLOC_RANK_W-1:0] alloc_rank_unused;
  logic [ALLOC_RANK_W-1:0]                  alloc_total;
  logic [ALLOC_RANK_W-1:0]                  grant_num;

  issue_queue_free_list_compactor #(.LANES(FREE_WIDTH), .RANK_W(REL_RANK_W)) u_rel_compactor (
    .valid_i (releaseValid),
    .rank_o  (rel_rank),
    .total_o (rel_total)
  );

  issue_queue_free_list_compactor #(.LANES(ALLOC_WIDTH), .RANK_W(ALLOC_RANK_W)) u_alloc_popcnt (
    .valid_i (allocReq),
    .rank_o  (alloc_rank_unused),
    .total_o (alloc_total)
  );

  // Grants are all-or-nothing: only when a full ALLOC_WIDTH group is available.
  assign allocatable = (state_q == IQ_FL_READY) && (count_q >= CNT_W'(ALLOC_WIDTH));
  assign grant_num   = allocatable ? alloc_total : '0;
  assign freeCount   = count_q;
  assign initDone    = init_done_q;

  // Same-cycle read of the next ALLOC_WIDTH head slots.
  always_comb begin
    allocPtr = '0;
    for (int unsigned i = 0; i < ALLOC_WIDTH; i++) begin
      allocPtr[i] = mem_q[wrap_add(head_q, i)];
    end
  end

  // Next-state and memory write lanes.
  always_comb begin
    int unsigned base;
    int unsigned n;
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    base        = 0;
    n           = 0;
    for (int unsigned k = 0; k < FREE_WIDTH; k++) wr_c[k] = '0;

    case (state_q)
      IQ_FL_INIT: begin
        // Load FREE_WIDTH consecutive indices per cycle; last chunk may be short.
        base = 32'(init_cnt_q) * FREE_WIDTH;
        for (int unsigned k = 0; k < FREE_WIDTH; k++) begin
          if (base + k < ENTRY_NUM) begin
            wr_c[k].we   = 1'b1;
            wr_c[k].addr = wrap_add(tail_q, k);
            wr_c[k].data = IssueQueueIndexPath'(base + k);
            n = n + 1;
          end
        end
        tail_d     = wrap_add(tail_q, n);
        count_d    = CNT_W'(32'(count_q) + n);
        init_cnt_d = init_cnt_q + INIT_CNT_W'(1);
        if (32'(init_cnt_q) == ISSUE_QUEUE_FREE_LIST_INIT_CYCLE - 1) begin
          state_d     = IQ_FL_READY;
          init_done_d = 1'b1;
        end
      end
      IQ_FL_READY: begin
        for (int unsigned k = 0; k < FREE_WIDTH; k++) begin
          wr_c[k].we   = releaseValid[k];
          wr_c[k].addr = wrap_add(tail_q, 32'(rel_rank[k]));
          wr_c[k].data = releasePtr[k];
        end
        head_d  = wrap_add(head_q, 32'(grant_num));
        tail_d  = wrap_add(tail_q, 32'(rel_total));
        count_d = CNT_W'(32'(count_q) - 32'(grant_num) + 32'(rel_total));
      end
      default: state_d = IQ_FL_INIT;
    endcase
  end

  // Index storage; contents are don't-care until INIT has written them.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < FREE_WIDTH; k++) begin
      if (wr_c[k].we) mem_q[wr_c[k].addr] <= wr_c[k].data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IQ_FL_INIT;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

`ifdef ISSUE_QUEUE_FREE_LIST_CHECK_EN
  logic [ENTRY_NUM-1:0] free_map_q, free_map_d;
  logic                 dfe_q;
  logic                 dfe_now_c;

  // Shadow bitmap of free indices; flags releases that break the free-list contract.
  always_comb begin
    free_map_d = free_map_q;
    dfe_now_c  = 1'b0;
    if (state_q == IQ_FL_INIT) begin
      for (int unsigned k = 0; k < FREE_WIDTH; k++) begin
        if (wr_c[k].we) free_map_d[wr_c[k].data] = 1'b1;
      end
    end else begin
      for (int unsigned i = 0; i < ALLOC_WIDTH; i++) begin
        if (allocatable && allocReq[i]) free_map_d[allocPtr[i]] = 1'b0;
      end
      for (int unsigned k = 0; k < FREE_WIDTH; k++) begin
        if (releaseValid[k]) begin
          if (free_map_q[releasePtr[k]]) dfe_now_c = 1'b1;
          for (int unsigned j = 0; j < k; j++) begin
            if (releaseValid[j] && (releasePtr[j] == releasePtr[k])) dfe_now_c = 1'b1;
          end
          free_map_d[releasePtr[k]] = 1'b1;
        end
      end
      if (32'(count_q) + 32'(rel_total) > ENTRY_NUM) dfe_now_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_map_q <= '0;
      dfe_q      <= 1'b0;
    end else begin
      free_map_q <= free_map_d;
      dfe_q      <= dfe_q | dfe_now_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!dfe_now_c);
    end
  end

  assign doubleFreeError = dfe_q;
`endif

endmodule
